// File: rtl/tawas_ls_unit_if.sv
// Data-RAM bus and write-back bundle of the Tawas load/store unit.
// The master side is the load/store unit; the slave side is the data RAM and register file.
interface tawas_ls_unit_if;
    logic        D_CS;
    logic        D_WE;
    logic [31:0] D_ADDR;
    logic [3:0]  D_MASK;
    logic [31:0] D_DOUT;
    logic [31:0] D_DIN;

    logic        LS_PTR_UPD_VLD;
    logic [2:0]  LS_PTR_UPD_SEL;
    logic [31:0] LS_PTR_UPD;
    logic        LS_LOAD_VLD;
    logic [2:0]  LS_LOAD_SEL;
    logic [31:0] LS_LOAD;
    logic        LS_FAULT;

    modport master (
        output D_CS, D_WE, D_ADDR, D_MASK, D_DOUT,
        input  D_DIN,
        output LS_PTR_UPD_VLD, LS_PTR_UPD_SEL, LS_PTR_UPD,
        output LS_LOAD_VLD, LS_LOAD_SEL, LS_LOAD, LS_FAULT
    );

    modport slave (
        input  D_CS, D_WE, D_ADDR, D_MASK, D_DOUT,
        output D_DIN,
        input  LS_PTR_UPD_VLD, LS_PTR_UPD_SEL, LS_PTR_UPD,
        input  LS_LOAD_VLD, LS_LOAD_SEL, LS_LOAD, LS_FAULT
    );
endinterface

// File: rtl/tawas_ls_unit.sv
// Tawas load/store stage: issue -> bus -> pointer update -> load align, fixed latencies.
// Optional macro TAWAS_LS_MISALIGN_TRAP_EN traps misaligned half/word accesses instead of aligning them.
module tawas_ls_unit (
    input  logic                   CLK,
    input  logic                   RST,

    input  logic                   LS_VLD,
    input  logic                   LS_WR,
    input  logic [1:0]             LS_SIZE,
    input  logic                   LS_SIGNED,
    input  logic                   LS_PRE,
    input  logic                   LS_UPD,
    input  logic [7:0]             LS_OFFSET,
    input  logic [2:0]             LS_PTR_SEL,
    input  logic [2:0]             LS_LOAD_SEL,
    input  logic [31:0]            LS_PTR,
    input  logic [31:0]            LS_STORE,

    tawas_ls_unit_if.master        ls_bus
);

    // Issue stage (combinational)
    logic [1:0]  i_size;
    logic [31:0] i_eff;
    logic [31:0] i_sum;
    logic [31:0] i_addr;
    logic [1:0]  i_lane;
    logic [3:0]  i_mask;
    logic [31:0] i_dout;
    logic        i_trap;
    logic        i_go;

    always_comb begin
        i_size = (LS_SIZE == 2'd3) ? 2'd2 : LS_SIZE;
        i_eff  = {{24{LS_OFFSET[7]}}, LS_OFFSET} << i_size;
        i_sum  = LS_PTR + i_eff;
        i_addr = LS_PRE ? i_sum : LS_PTR;

        i_lane = 2'b00;
        i_mask = 4'b1111;
        i_dout = LS_STORE;
        case (i_size)
            2'd0: begin
                i_lane = i_addr[1:0];
                i_mask = 4'b0001 << i_addr[1:0];
                i_dout = {4{LS_STORE[7:0]}};
            end
            2'd1: begin
                // Low address bit dropped: a misaligned half lands on its aligned lane pair.
                i_lane = {i_addr[1], 1'b0};
                i_mask = i_addr[1] ? 4'b1100 : 4'b0011;
                i_dout = {2{LS_STORE[15:0]}};
            end
            default: begin
                i_lane = 2'b00;
                i_mask = 4'b1111;
                i_dout = LS_STORE;
            end
        endcase
    end

`ifdef TAWAS_LS_MISALIGN_TRAP_EN
    logic i_misalign;
    assign i_misalign = ((i_size == 2'd1) && i_addr[0]) ||
                        ((i_size == 2'd2) && (i_addr[1:0] != 2'b00));
    assign i_trap = LS_VLD && i_misalign;
`else
    assign i_trap = 1'b0;
`endif

    assign i_go = LS_VLD && !i_trap;

    // Bus stage registers (cycle N+1)
    logic        d_cs;
    logic        d_we;
    logic [31:0] d_addr;
    logic [3:0]  d_mask;
    logic [31:0] d_dout;
    logic        fault;

    logic        b_upd_vld;
    logic [2:0]  b_upd_sel;
    logic [31:0] b_upd_val;
    logic        b_ld_vld;
    logic [2:0]  b_ld_sel;
    logic [1:0]  b_size;
    logic        b_signed;
    logic [1:0]  b_lane;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            d_cs      <= 1'b0;
            d_we      <= 1'b0;
            d_addr    <= '0;
            d_mask    <= '0;
            d_dout    <= '0;
            fault     <= 1'b0;
            b_upd_vld <= 1'b0;
            b_upd_sel <= '0;
            b_upd_val <= '0;
            b_ld_vld  <= 1'b0;
            b_ld_sel  <= '0;
            b_size    <= '0;
            b_signed  <= 1'b0;
            b_lane    <= '0;
        end else begin
            d_cs      <= i_go;
            d_we      <= i_go && LS_WR;
            d_addr    <= i_go ? {i_addr[31:2], 2'b00} : '0;
            d_mask    <= i_go ? i_mask : '0;
            d_dout    <= (i_go && LS_WR) ? i_dout : '0;
            fault     <= i_trap;
            b_upd_vld <= i_go && LS_UPD;
            b_upd_sel <= LS_PTR_SEL;
            b_upd_val <= i_sum;
            b_ld_vld  <= i_go && !LS_WR;
            b_ld_sel  <= LS_LOAD_SEL;
            b_size    <= i_size;
            b_signed  <= LS_SIGNED;
            b_lane    <= i_lane;
        end
    end

    // Pointer-update stage registers (cycle N+2)
    logic        u_upd_vld;
    logic [2:0]  u_upd_sel;
    logic [31:0] u_upd_val;
    logic        u_ld_vld;
    logic [2:0]  u_ld_sel;
    logic [1:0]  u_size;
    logic        u_signed;
    logic [1:0]  u_lane;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            u_upd_vld <= 1'b0;
            u_upd_sel <= '0;
            u_upd_val <= '0;
            u_ld_vld  <= 1'b0;
            u_ld_sel  <= '0;
            u_size    <= '0;
            u_signed  <= 1'b0;
            u_lane    <= '0;
        end else begin
            u_upd_vld <= b_upd_vld;
            u_upd_sel <= b_upd_vld ? b_upd_sel : '0;
            u_upd_val <= b_upd_vld ? b_upd_val : '0;
            u_ld_vld  <= b_ld_vld;
            u_ld_sel  <= b_ld_sel;
            u_size    <= b_size;
            u_signed  <= b_signed;
            u_lane    <= b_lane;
        end
    end

    // Load stage registers (cycle N+3); RAM word captured at the end of N+2
    logic        l_vld;
    logic [2:0]  l_sel;
    logic [1:0]  l_size;
    logic        l_signed;
    logic [1:0]  l_lane;
    logic [31:0] l_word;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            l_vld    <= 1'b0;
            l_sel    <= '0;
            l_size   <= '0;
            l_signed <= 1'b0;
            l_lane   <= '0;
            l_word   <= '0;
        end else begin
            l_vld    <= u_ld_vld;
            l_sel    <= u_ld_vld ? u_ld_sel : '0;
            l_size   <= u_ld_vld ? u_size : '0;
            l_signed <= u_ld_vld && u_signed;
            l_lane   <= u_ld_vld ? u_lane : '0;
            l_word   <= u_ld_vld ? ls_bus.D_DIN : '0;
        end
    end

    logic [7:0]  l_byte;
    logic [15:0] l_half;
    logic [31:0] l_data;

    always_comb begin
        l_byte = l_word[7:0];
        case (l_lane)
            2'd0:    l_byte = l_word[7:0];
            2'd1:    l_byte = l_word[15:8];
            2'd2:    l_byte = l_word[23:16];
            default: l_byte = l_word[31:24];
        endcase
        l_half = l_lane[1] ? l_word[31:16] : l_word[15:0];

        l_data = l_word;
        case (l_size)
            2'd0:    l_data = l_signed ? {{24{l_byte[7]}}, l_byte} : {24'b0, l_byte};
            2'd1:    l_data = l_signed ? {{16{l_half[15]}}, l_half} : {16'b0, l_half};
            default: l_data = l_word;
        endcase
    end

    assign ls_bus.D_CS           = d_cs;
    assign ls_bus.D_WE           = d_we;
    assign ls_bus.D_ADDR         = d_addr;
    assign ls_bus.D_MASK         = d_mask;
    assign ls_bus.D_DOUT         = d_dout;
    assign ls_bus.LS_FAULT       = fault;
    assign ls_bus.LS_PTR_UPD_VLD = u_upd_vld;
    assign ls_bus.LS_PTR_UPD_SEL = u_upd_sel;
    assign ls_bus.LS_PTR_UPD     = u_upd_val;
    assign ls_bus.LS_LOAD_VLD    = l_vld;
    assign ls_bus.LS_LOAD_SEL    = l_sel;
    assign ls_bus.LS_LOAD        = l_data;

endmodule

// File: tb/tb_tawas_ls_unit.sv
// Directed self-checking bench for tawas_ls_unit with a behavioural single-cycle data RAM.
// Expectations for the misaligned case follow TAWAS_LS_MISALIGN_TRAP_EN when defined.
module tb_tawas_ls_unit;

    logic        CLK;
    logic        RST;
    logic        LS_VLD;
    logic        LS_WR;
    logic [1:0]  LS_SIZE;
    logic        LS_SIGNED;
    logic        LS_PRE;
    logic        LS_UPD;
    logic [7:0]  LS_OFFSET;
    logic [2:0]  LS_PTR_SEL;
    logic [2:0]  LS_LOAD_SEL;
    logic [31:0] LS_PTR;
    logic [31:0] LS_STORE;

    int unsigned checks;
    int unsigned errors;

    tawas_ls_unit_if bus ();

    tawas_ls_unit dut (
        .CLK         (CLK),
        .RST         (RST),
        .LS_VLD      (LS_VLD),
        .LS_WR       (LS_WR),
        .LS_SIZE     (LS_SIZE),
        .LS_SIGNED   (LS_SIGNED),
        .LS_PRE      (LS_PRE),
        .LS_UPD      (LS_UPD),
        .LS_OFFSET   (LS_OFFSET),
        .LS_PTR_SEL  (LS_PTR_SEL),
        .LS_LOAD_SEL (LS_LOAD_SEL),
        .LS_PTR      (LS_PTR),
        .LS_STORE    (LS_STORE),
        .ls_bus      (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Data RAM: 1024 words, one cycle read latency, byte-masked writes
    logic [31:0] mem [0:1023];

    always @(posedge CLK) begin
        if (bus.D_CS) begin
            if (bus.D_WE) begin
                for (int i = 0; i < 4; i++)
                    if (bus.D_MASK[i])
                        mem[bus.D_ADDR[11:2]][i*8 +: 8] <= bus.D_DOUT[i*8 +: 8];
            end else begin
                bus.D_DIN <= mem[bus.D_ADDR[11:2]];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic issue(input logic wr, input logic [1:0] size, input logic sgn,
                         input logic pre, input logic upd, input logic [7:0] off,
                         input logic [2:0] psel, input logic [2:0] lsel,
                         input logic [31:0] ptr, input logic [31:0] st);
        LS_VLD      = 1'b1;
        LS_WR       = wr;
        LS_SIZE     = size;
        LS_SIGNED   = sgn;
        LS_PRE      = pre;
        LS_UPD      = upd;
        LS_OFFSET   = off;
        LS_PTR_SEL  = psel;
        LS_LOAD_SEL = lsel;
        LS_PTR      = ptr;
        LS_STORE    = st;
    endtask

    task automatic idle();
        LS_VLD = 1'b0;
        LS_WR  = 1'b0;
        LS_UPD = 1'b0;
    endtask

    logic [31:0] exp_ld  [0:3];
    logic [2:0]  exp_sel [0:3];

    initial begin
        checks = 0;
        errors = 0;
        RST    = 1'b1;
        idle();
        LS_SIZE = '0; LS_SIGNED = 1'b0; LS_PRE = 1'b0; LS_OFFSET = '0;
        LS_PTR_SEL = '0; LS_LOAD_SEL = '0; LS_PTR = '0; LS_STORE = '0;

        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[32'h104 >> 2] = 32'hDEADBEEF;
        mem[32'h300 >> 2] = 32'h80FF1234;
        mem[32'h400 >> 2] = 32'hCAFEF00D;
        mem[32'h010 >> 2] = 32'hA5A50001;
        mem[32'h014 >> 2] = 32'h11223344;
        mem[32'h018 >> 2] = 32'h55667788;
        mem[1023]         = 32'h0BADF00D;

        tick(); tick();
        chk("rst_d_cs",    {31'b0, bus.D_CS}, 32'h0);
        chk("rst_d_addr",  bus.D_ADDR, 32'h0);
        chk("rst_upd_vld", {31'b0, bus.LS_PTR_UPD_VLD}, 32'h0);
        chk("rst_ld_vld",  {31'b0, bus.LS_LOAD_VLD}, 32'h0);
        chk("rst_load",    bus.LS_LOAD, 32'h0);
        chk("rst_fault",   {31'b0, bus.LS_FAULT}, 32'h0);
        RST = 1'b0;
        tick();

        // Word load with pre-increment and pointer update
        issue(1'b0, 2'd2, 1'b0, 1'b1, 1'b1, 8'd1, 3'd3, 3'd5, 32'h100, 32'h0);
        tick(); idle();
        chk("wl_cs",   {31'b0, bus.D_CS}, 32'h1);
        chk("wl_we",   {31'b0, bus.D_WE}, 32'h0);
        chk("wl_addr", bus.D_ADDR, 32'h104);
        chk("wl_mask", {28'b0, bus.D_MASK}, 32'hF);
        tick();
        chk("wl_upd_vld", {31'b0, bus.LS_PTR_UPD_VLD}, 32'h1);
        chk("wl_upd_sel", {29'b0, bus.LS_PTR_UPD_SEL}, 32'h3);
        chk("wl_upd",     bus.LS_PTR_UPD, 32'h104);
        chk("wl_ld_early", {31'b0, bus.LS_LOAD_VLD}, 32'h0);
        tick();
        chk("wl_ld_vld", {31'b0, bus.LS_LOAD_VLD}, 32'h1);
        chk("wl_ld_sel", {29'b0, bus.LS_LOAD_SEL}, 32'h5);
        chk("wl_load",   bus.LS_LOAD, 32'hDEADBEEF);
        chk("wl_upd_off", {31'b0, bus.LS_PTR_UPD_VLD}, 32'h0);

        // Byte store to lane 3
        issue(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd1, 3'd1, 32'h203, 32'h12345678);
        tick(); idle();
        chk("bs_cs",   {31'b0, bus.D_CS}, 32'h1);
        chk("bs_we",   {31'b0, bus.D_WE}, 32'h1);
        chk("bs_addr", bus.D_ADDR, 32'h200);
        chk("bs_mask", {28'b0, bus.D_MASK}, 32'h8);
        chk("bs_dout", bus.D_DOUT, 32'h78787878);
        tick();
        chk("bs_upd_vld", {31'b0, bus.LS_PTR_UPD_VLD}, 32'h0);
        tick();
        chk("bs_ld_vld", {31'b0, bus.LS_LOAD_VLD}, 32'h0);

        // Signed then unsigned half load from the upper half
        issue(1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 8'd0, 3'd0, 3'd2, 32'h302, 32'h0);
        tick();
        issue(1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0, 3'd6, 32'h302, 32'h0);
        chk("hs_mask", {28'b0, bus.D_MASK}, 32'hC);
        tick(); idle();
        tick();
        chk("hs_load", bus.LS_LOAD, 32'hFFFF80FF);
        chk("hs_sel",  {29'b0, bus.LS_LOAD_SEL}, 32'h2);
        tick();
        chk("hu_load", bus.LS_LOAD, 32'h000080FF);
        chk("hu_sel",  {29'b0, bus.LS_LOAD_SEL}, 32'h6);

        // Four back-to-back loads; the last one wraps its pointer to zero
        exp_ld[0] = 32'hA5A50001; exp_sel[0] = 3'd1;
        exp_ld[1] = 32'h00000033; exp_sel[1] = 3'd2;
        exp_ld[2] = 32'hFFFFFF88; exp_sel[2] = 3'd3;
        exp_ld[3] = 32'h0BADF00D; exp_sel[3] = 3'd4;
        tick();
        for (int k = 0; k < 7; k++) begin
            case (k)
                0: issue(1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0, 3'd1, 32'h10, 32'h0);
                1: issue(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0, 3'd2, 32'h15, 32'h0);
                2: issue(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 8'd0, 3'd0, 3'd3, 32'h18, 32'h0);
                3: issue(1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 8'd1, 3'd7, 3'd4, 32'hFFFFFFFC, 32'h0);
                default: idle();
            endcase
            tick();
            if (k >= 2 && k <= 5) begin
                chk("b2b_ld_vld", {31'b0, bus.LS_LOAD_VLD}, 32'h1);
                chk("b2b_ld_sel", {29'b0, bus.LS_LOAD_SEL}, {29'b0, exp_sel[k-2]});
                chk("b2b_load",   bus.LS_LOAD, exp_ld[k-2]);
            end else if (k == 6) begin
                chk("b2b_ld_end", {31'b0, bus.LS_LOAD_VLD}, 32'h0);
            end
            if (k == 4) begin
                chk("wrap_upd_vld", {31'b0, bus.LS_PTR_UPD_VLD}, 32'h1);
                chk("wrap_upd_sel", {29'b0, bus.LS_PTR_UPD_SEL}, 32'h7);
                chk("wrap_upd",     bus.LS_PTR_UPD, 32'h0);
            end else if (k >= 1) begin
                chk("b2b_upd_vld", {31'b0, bus.LS_PTR_UPD_VLD}, 32'h0);
            end
        end

        // Misaligned word load at 0x401
        issue(1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 8'd0, 3'd2, 3'd6, 32'h401, 32'h0);
        tick(); idle();
`ifdef TAWAS_LS_MISALIGN_TRAP_EN
        chk("mis_cs",    {31'b0, bus.D_CS}, 32'h0);
        chk("mis_fault", {31'b0, bus.LS_FAULT}, 32'h1);
        tick();
        chk("mis_fault_end", {31'b0, bus.LS_FAULT}, 32'h0);
        chk("mis_upd_vld",   {31'b0, bus.LS_PTR_UPD_VLD}, 32'h0);
        tick();
        chk("mis_ld_vld", {31'b0, bus.LS_LOAD_VLD}, 32'h0);
`else
        chk("mis_cs",    {31'b0, bus.D_CS}, 32'h1);
        chk("mis_addr",  bus.D_ADDR, 32'h400);
        chk("mis_fault", {31'b0, bus.LS_FAULT}, 32'h0);
        tick();
        chk("mis_upd_vld", {31'b0, bus.LS_PTR_UPD_VLD}, 32'h1);
        chk("mis_upd",     bus.LS_PTR_UPD, 32'h401);
        tick();
        chk("mis_ld_vld", {31'b0, bus.LS_LOAD_VLD}, 32'h1);
        chk("mis_load",   bus.LS_LOAD, 32'hCAFEF00D);
`endif

        // Reset asserted one cycle after an issue discards the op
        tick();
        issue(1'b0, 2'd2, 1'b0, 1'b1, 1'b1, 8'd1, 3'd3, 3'd5, 32'h100, 32'h0);
        tick(); idle();
        RST = 1'b1;
        #1;
        chk("arst_cs",   {31'b0, bus.D_CS}, 32'h0);
        chk("arst_addr", bus.D_ADDR, 32'h0);
        chk("arst_mask", {28'b0, bus.D_MASK}, 32'h0);
        tick();
        RST = 1'b0;
        chk("arst_upd_vld_hold", {31'b0, bus.LS_PTR_UPD_VLD}, 32'h0);
        tick();
        chk("arst_upd_vld", {31'b0, bus.LS_PTR_UPD_VLD}, 32'h0);
        chk("arst_ld_vld",  {31'b0, bus.LS_LOAD_VLD}, 32'h0);
        tick();
        chk("arst_ld_vld2", {31'b0, bus.LS_LOAD_VLD}, 32'h0);
        chk("arst_load",    bus.LS_LOAD, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
